// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter. Bytes written by the CPU queue in a FIFO and
// are shifted out LSB first; status, divisor and interrupt are visible to firmware.
module bus_uart_tx #(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] BAUD_DIV  = 16'd16
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  cpu_wdata,
    input  logic        mem_write,
    input  logic        mem_req,
    output logic [7:0]  cpu_rdata,
    output logic        rd_valid,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
    localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [7:0]    fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [3:0]    count_q;
    logic [3:0]    count_d;
    logic          ovf_q;
    logic [15:0]   div_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          irq_q;
    logic [7:0]    rdata_q;
    logic          rd_valid_q;

    logic          sel_s;
    logic [3:0]    offset_s;
    logic          wr_s;
    logic          rd_s;
    logic          empty_s;
    logic          full_s;
    logic          busy_s;
    logic [15:0]   div_eff_s;
    logic          bit_end_s;
    logic          pop_s;
    logic          push_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic          idle_next_s;
    logic [7:0]    status_s;
    logic [7:0]    rdata_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign sel_s       = mem_req && (address[15:4] == BASE_ADDR[15:4]);
    assign offset_s    = address[3:0];
    assign wr_s        = sel_s && mem_write;
    assign rd_s        = sel_s && !mem_write;
    assign empty_s     = (count_q == 4'd0);
    assign full_s      = (count_q == DEPTH_C);
    assign busy_s      = (state_q != S_IDLE);
    assign div_eff_s   = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end_s   = (baud_q == 16'd0);
    // The FSM takes the next byte either from idle or at the end of a stop bit.
    assign pop_s       = !empty_s && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_s));
    assign push_s      = wr_s && (offset_s == 4'd0);
    assign push_ok_s   = push_s && !full_s;
    assign ovf_set_s   = push_s && full_s;
    assign idle_next_s = !pop_s && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_s));
    assign status_s    = {count_q, ovf_q, busy_s, full_s, empty_s};

    assign cpu_rdata = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign tx        = tx_q;
    assign irq       = irq_q;

    // Next FIFO occupancy; a pop on a full FIFO is not credited to a same-edge push.
    always_comb begin
        count_d = count_q;
        if (push_ok_s && !pop_s) begin
            count_d = count_q + 4'd1;
        end else if (!push_ok_s && pop_s) begin
            count_d = count_q - 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Register read mux.
    always_comb begin
        rdata_s = 8'h00;
        case (offset_s)
            4'd1:    rdata_s = status_s;
            4'd2:    rdata_s = div_q[7:0];
            4'd3:    rdata_s = div_q[15:8];
            default: rdata_s = 8'h00;
        endcase
    end

    // FIFO storage; contents are meaningless while count is zero so no reset is needed.
    always_ff @(posedge ph2) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= 4'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    // Bus-visible registers: divisor, overflow flag and registered read data.
    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            div_q      <= BAUD_DIV;
            ovf_q      <= 1'b0;
            rdata_q    <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_s;
            if (rd_s) begin
                rdata_q <= rdata_s;
            end
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end else if (rd_s && (offset_s == 4'd1)) begin
                ovf_q <= 1'b0;
            end
            if (wr_s && (offset_s == 4'd2)) begin
                div_q[7:0] <= cpu_wdata;
            end
            if (wr_s && (offset_s == 4'd3)) begin
                div_q[15:8] <= cpu_wdata;
            end
        end
    end

    // Transmit FSM; the divisor is re-sampled at every bit boundary.
    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            irq_q <= (count_d == 4'd0) && idle_next_s;
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        shift_q <= fifo_q[rd_ptr_q];
                        baud_q  <= div_eff_s - 16'd1;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        baud_q  <= div_eff_s - 16'd1;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        baud_q <= div_eff_s - 16'd1;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        if (pop_s) begin
                            shift_q <= fifo_q[rd_ptr_q];
                            baud_q  <= div_eff_s - 16'd1;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: bus register tests, cycle-exact serial timing,
// and a serial monitor that decodes frames against a queue of expected bytes.
`timescale 1ns/1ps
module tb_bus_uart_tx;

    logic        ph2 = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        mem_write = 1'b0;
    logic        mem_req = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        rd_valid;
    logic        tx;
    logic        irq;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b1;
    int          mon_div = 16;
    int          mon_d;
    logic [7:0]  mon_byte;
    logic [7:0]  mon_exp;

    bus_uart_tx dut (
        .ph2       (ph2),
        .reset     (reset),
        .address   (address),
        .cpu_wdata (cpu_wdata),
        .mem_write (mem_write),
        .mem_req   (mem_req),
        .cpu_rdata (cpu_rdata),
        .rd_valid  (rd_valid),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 ph2 = ~ph2;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "timeout");
    end

    // Serial monitor: samples each bit at its middle and checks against the scoreboard.
    always begin
        @(negedge ph2);
        if (mon_en && reset === 1'b1 && tx === 1'b0) begin
            mon_d = mon_div;
            repeat (mon_d / 2) @(negedge ph2);
            n_checks++;
            if (tx !== 1'b0) begin
                n_fail++;
                $display("FAIL mon_start_bit: got %b, expected 0", tx);
            end
            for (int i = 0; i < 8; i++) begin
                repeat (mon_d) @(negedge ph2);
                mon_byte[i] = tx;
            end
            repeat (mon_d) @(negedge ph2);
            n_checks++;
            if (tx !== 1'b1) begin
                n_fail++;
                $display("FAIL mon_stop_bit: got %b, expected 1", tx);
            end
            repeat (mon_d - mon_d / 2 - 1) @(negedge ph2);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_frame: got unexpected byte %h, expected no frame", mon_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_byte !== mon_exp) begin
                    n_fail++;
                    $display("FAIL mon_frame: got %h, expected %h", mon_byte, mon_exp);
                end
            end
        end
    end

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge ph2);
        address   = addr;
        cpu_wdata = data;
        mem_write = 1'b1;
        mem_req   = 1'b1;
        @(negedge ph2);
        mem_req   = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data, output logic valid);
        @(negedge ph2);
        address   = addr;
        mem_write = 1'b0;
        mem_req   = 1'b1;
        @(negedge ph2);
        data    = cpu_rdata;
        valid   = rd_valid;
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic       rv;
        reset = 1'b0;
        repeat (3) @(negedge ph2);
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1 || rd_valid !== 1'b0 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%b irq=%b rv=%b rd=%h, expected 1 1 0 00", tx, irq, rd_valid, cpu_rdata);
        end
        reset = 1'b1;
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h01 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: got %h/%b, expected 01/1", rd, rv);
        end
        bus_read(16'hE002, rd, rv);
        n_checks++;
        if (rd !== 8'h10 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_div_lo: got %h/%b, expected 10/1", rd, rv);
        end
        bus_read(16'hE003, rd, rv);
        n_checks++;
        if (rd !== 8'h00 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_div_hi: got %h/%b, expected 00/1", rd, rv);
        end
        bus_read(16'hE002, rd, rv);
        @(negedge ph2);
        n_checks++;
        if (rd_valid !== 1'b0 || cpu_rdata !== 8'h10) begin
            n_fail++;
            $display("FAIL rdata_hold: got rv=%b rd=%h, expected 0 10", rd_valid, cpu_rdata);
        end
        bus_write(16'hD002, 8'h55);
        bus_read(16'hE002, rd, rv);
        n_checks++;
        if (rd !== 8'h10) begin
            n_fail++;
            $display("FAIL unselected_write: got %h, expected 10", rd);
        end
        bus_read(16'hE007, rd, rv);
        n_checks++;
        if (rd !== 8'h00 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_read: got %h/%b, expected 00/1", rd, rv);
        end
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_lines: got tx=%b irq=%b, expected 1 1", tx, irq);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat = 8'hA5;
        logic       exp_bit;
        bus_write(16'hE002, 8'd4);
        bus_write(16'hE003, 8'd0);
        mon_div = 4;
        exp_q.push_back(pat);
        bus_write(16'hE000, pat);
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_after_push: got tx=%b irq=%b, expected 1 0", tx, irq);
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge ph2);
            exp_bit = (c <= 4) ? 1'b0 : (c <= 36) ? pat[(c - 5) / 4] : 1'b1;
            n_checks++;
            if (tx !== exp_bit) begin
                n_fail++;
                $display("FAIL frame_a5_cycle%0d: got tx=%b, expected %b", c, tx, exp_bit);
            end
        end
        @(negedge ph2);
        n_checks++;
        if (irq !== 1'b1 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end_irq: got irq=%b tx=%b, expected 1 1", irq, tx);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] rd;
        logic       rv;
        int         waited = 0;
        bus_write(16'hE002, 8'd20);
        mon_div = 20;
        for (int b = 0; b < 9; b++) begin
            exp_q.push_back(8'(b));
            bus_write(16'hE000, 8'(b));
        end
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h86) begin
            n_fail++;
            $display("FAIL status_full: got %h, expected 86", rd);
        end
        bus_write(16'hE000, 8'h09);
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h8E) begin
            n_fail++;
            $display("FAIL status_ovf_set: got %h, expected 8e", rd);
        end
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h86) begin
            n_fail++;
            $display("FAIL status_ovf_cleared: got %h, expected 86", rd);
        end
        while (!(irq === 1'b1 && exp_q.size() == 0) && waited < 3000) begin
            @(negedge ph2);
            waited++;
        end
        n_checks++;
        if (waited >= 3000) begin
            n_fail++;
            $display("FAIL fifo_drain: got %0d bytes pending irq=%b, expected 0 and 1", exp_q.size(), irq);
        end
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h01) begin
            n_fail++;
            $display("FAIL status_drained: got %h, expected 01", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic       rv;
        bus_write(16'hE002, 8'd2);
        mon_div = 2;
        exp_q.push_back(8'h3C);
        bus_write(16'hE000, 8'h3C);
        exp_q.push_back(8'hC3);
        bus_write(16'hE000, 8'hC3);
        repeat (18) @(negedge ph2);
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop1: got tx=%b irq=%b, expected 1 0", tx, irq);
        end
        @(negedge ph2);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got tx=%b, expected 0", tx);
        end
        repeat (19) @(negedge ph2);
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop2: got tx=%b irq=%b, expected 1 0", tx, irq);
        end
        @(negedge ph2);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_irq: got %b, expected 1", irq);
        end
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_status: got %h, expected 01", rd);
        end
    endtask

    task automatic test_divisor();
        logic [7:0] p0 = 8'h5A;
        logic [7:0] p1 = 8'hA6;
        logic       exp_bit;
        mon_en = 1'b0;
        bus_write(16'hE002, 8'd0);
        bus_write(16'hE000, p0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge ph2);
            exp_bit = (c == 1) ? 1'b0 : (c <= 9) ? p0[c - 2] : 1'b1;
            n_checks++;
            if (tx !== exp_bit) begin
                n_fail++;
                $display("FAIL div0_cycle%0d: got tx=%b, expected %b", c, tx, exp_bit);
            end
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_irq: got %b, expected 1", irq);
        end
        bus_write(16'hE000, p1);
        bus_write(16'hE002, 8'd8);
        n_checks++;
        if (tx !== p1[0]) begin
            n_fail++;
            $display("FAIL divchg_bit0: got tx=%b, expected %b", tx, p1[0]);
        end
        for (int c = 3; c <= 66; c++) begin
            @(negedge ph2);
            exp_bit = (c <= 58) ? p1[1 + (c - 3) / 8] : 1'b1;
            n_checks++;
            if (tx !== exp_bit) begin
                n_fail++;
                $display("FAIL divchg_cycle%0d: got tx=%b, expected %b", c, tx, exp_bit);
            end
        end
        @(negedge ph2);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL divchg_irq: got %b, expected 1", irq);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rd;
        logic       rv;
        int         bad = 0;
        bus_write(16'hE002, 8'd4);
        bus_write(16'hE000, 8'h81);
        bus_write(16'hE000, 8'h7E);
        repeat (8) @(negedge ph2);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_data: got tx=%b, expected 0", tx);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got tx=%b irq=%b, expected 1 1", tx, irq);
        end
        repeat (2) @(negedge ph2);
        reset = 1'b1;
        bus_read(16'hE001, rd, rv);
        n_checks++;
        if (rd !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_fifo_empty: got %h, expected 01", rd);
        end
        bus_read(16'hE002, rd, rv);
        n_checks++;
        if (rd !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_div_restored: got %h, expected 10", rd);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge ph2);
            if (tx !== 1'b1 || irq !== 1'b1) begin
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_resume: got %0d active cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_overflow();
        test_back_to_back();
        test_divisor();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d bytes, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
